// File: rtl/gmul_seq.sv
// rtl/gmul_seq.sv - digit-serial GF(2^WIDTH) multiplier with valid/ready handshakes
// Consumes DIGIT multiplier bits per cycle, MSB first, Horner-style accumulation.
module gmul_seq #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h1B,
  parameter int               DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("gmul_seq: WIDTH must be >= 2 and DIGIT must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_step;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_step;

  // DIGIT chained xtime/conditional-add sub-steps evaluated in one cycle.
  always_comb begin
    acc_step = acc;
    for (int i = 0; i < DIGIT; i++) begin
      acc_step = {acc_step[WIDTH-2:0], 1'b0}
               ^ (acc_step[WIDTH-1] ? POLY : '0)
               ^ (b_reg[WIDTH-1-i] ? a_reg : '0);
    end
  end

  assign last_step = (cnt == CW'(N - 1));
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_reg <= a_in;
        b_reg <= b_in;
        acc   <= '0;
        cnt   <= '0;
      end else if (state_q == BUSY) begin
        acc   <= acc_step;
        b_reg <= b_reg << DIGIT;
        cnt   <= cnt + 1'b1;
        if (last_step) data_out <= acc_step;
      end
    end
  end

endmodule

// File: tb/tb_gmul_seq.sv
// tb/tb_gmul_seq.sv - self-checking bench for gmul_seq across several field configurations
// Instances 0..3: GF(2^8) AES poly with DIGIT 1,2,4,8; instance 4: GF(2^4) poly 0x3, DIGIT 2.
module tb_gmul_seq;

  logic       clk;
  logic       rst;
  logic       iv   [5];
  logic       ordy [5];
  logic [7:0] a    [5];
  logic [7:0] b    [5];
  logic       rdy  [5];
  logic       ov   [5];
  logic       bz   [5];
  logic [7:0] dout [5];

  logic       rdy0, rdy1, rdy2, rdy3, rdy4;
  logic       ov0, ov1, ov2, ov3, ov4;
  logic       bz0, bz1, bz2, bz3, bz4;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] d4;

  int n_checks = 0;
  int n_fail   = 0;

  gmul_seq #(.WIDTH(8), .POLY(8'h1B), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy0), .a_in(a[0]), .b_in(b[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .data_out(d0), .busy(bz0));
  gmul_seq #(.WIDTH(8), .POLY(8'h1B), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy1), .a_in(a[1]), .b_in(b[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .data_out(d1), .busy(bz1));
  gmul_seq #(.WIDTH(8), .POLY(8'h1B), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy2), .a_in(a[2]), .b_in(b[2]),
    .out_valid(ov2), .out_ready(ordy[2]), .data_out(d2), .busy(bz2));
  gmul_seq #(.WIDTH(8), .POLY(8'h1B), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(rdy3), .a_in(a[3]), .b_in(b[3]),
    .out_valid(ov3), .out_ready(ordy[3]), .data_out(d3), .busy(bz3));
  gmul_seq #(.WIDTH(4), .POLY(4'h3), .DIGIT(2)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(rdy4), .a_in(a[4][3:0]), .b_in(b[4][3:0]),
    .out_valid(ov4), .out_ready(ordy[4]), .data_out(d4), .busy(bz4));

  always_comb begin
    rdy[0] = rdy0; rdy[1] = rdy1; rdy[2] = rdy2; rdy[3] = rdy3; rdy[4] = rdy4;
    ov[0]  = ov0;  ov[1]  = ov1;  ov[2]  = ov2;  ov[3]  = ov3;  ov[4]  = ov4;
    bz[0]  = bz0;  bz[1]  = bz1;  bz[2]  = bz2;  bz[3]  = bz3;  bz[4]  = bz4;
    dout[0] = d0;  dout[1] = d1;  dout[2] = d2;  dout[3] = d3;  dout[4] = {4'h0, d4};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full carry-less product first, then polynomial long-division remainder.
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                         input int w, input int poly);
    int p;
    p = 0;
    for (int i = 0; i < w; i++)
      if (y[i]) p = p ^ (int'(x) << i);
    for (int d = 2 * w - 2; d >= w; d--)
      if (p[d]) p = p ^ ((poly | (1 << w)) << (d - w));
    return p[7:0];
  endfunction

  task automatic run_op(input int i, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ex, input int n, input string tag);
    int cyc;
    int bcnt;
    @(negedge clk);
    a[i] = av; b[i] = bv; iv[i] = 1'b1; ordy[i] = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(rdy[i]), 1);
    @(negedge clk);
    iv[i] = 1'b0; a[i] = ~av; b[i] = ~bv;
    cyc = 0; bcnt = 0;
    while (!ov[i] && cyc < 40) begin
      bcnt += int'(bz[i]);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(n));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(n));
    check({tag, "_data"}, 32'(dout[i]), 32'(ex));
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(ov[i]), 0);
  endtask

  task automatic rand_run(input int i, input int ops);
    logic [7:0] q[$];
    logic [7:0] last;
    logic [7:0] want;
    logic       held, pend;
    int         sent, recv, guard;
    held = 1'b0; pend = 1'b0; last = '0;
    sent = 0; recv = 0; guard = 0;
    while ((sent < ops || q.size() != 0) && guard < 60000) begin
      @(negedge clk);
      guard++;
      if (pend) begin
        iv[i] = 1'b0;
        pend  = 1'b0;
      end
      if (!iv[i] && sent < ops && $urandom_range(0, 3) != 0) begin
        a[i]  = 8'($urandom);
        b[i]  = 8'($urandom);
        iv[i] = 1'b1;
      end
      ordy[i] = ($urandom_range(0, 2) != 0);
      #1;
      if (ov[i]) begin
        if (held) check("rnd_stable", 32'(dout[i]), 32'(last));
        if (ordy[i]) begin
          if (q.size() == 0) begin
            check("rnd_unexpected_valid", 32'(ov[i]), 0);
          end else begin
            want = q.pop_front();
            check("rnd_data", 32'(dout[i]), 32'(want));
            recv++;
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          last = dout[i];
        end
      end
      if (iv[i] && rdy[i]) begin
        q.push_back(ref_mul(a[i], b[i], 8, 'h1B));
        sent++;
        pend = 1'b1;
      end
    end
    iv[i]   = 1'b0;
    ordy[i] = 1'b1;
    check("rnd_result_count", 32'(recv), 32'(ops));
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 5; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; a[i] = '0; b[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("reset_in_ready", 32'(rdy[i]), 0);
      check("reset_out_valid", 32'(ov[i]), 0);
      check("reset_busy", 32'(bz[i]), 0);
      check("reset_data", 32'(dout[i]), 0);
    end
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 32'(rdy[0]), 1);

    // Abort mid-operation, then redo the same product.
    @(negedge clk);
    a[0] = 8'h57; b[0] = 8'h83; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 32'(ov[0]), 0);
    check("abort_data", 32'(dout[0]), 0);
    check("abort_busy", 32'(bz[0]), 0);
    check("abort_in_ready", 32'(rdy[0]), 0);
    rst = 1'b0;
    #1;
    check("abort_in_ready_after", 32'(rdy[0]), 1);
    run_op(0, 8'h57, 8'h83, 8'hC1, 8, "redo_57x83");

    run_op(0, 8'h57, 8'h83, 8'hC1, 8, "aes_57x83");
    run_op(0, 8'h57, 8'h0E, 8'h67, 8, "aes_57x0e");
    run_op(0, 8'h53, 8'hCA, 8'h01, 8, "aes_53xca");

    run_op(2, 8'hA5, 8'h01, 8'hA5, 2, "d4_a5x01");
    run_op(2, 8'h00, 8'hFF, 8'h00, 2, "d4_00xff");
    run_op(2, 8'hFF, 8'h00, 8'h00, 2, "d4_ffx00");

    run_op(4, 8'h09, 8'h07, ref_mul(8'h09, 8'h07, 4, 3), 2, "w4_9x7");
    run_op(4, 8'h0F, 8'h0F, 8'h0A, 2, "w4_fxf");

    // Backpressure in DONE, then a same-edge consume + accept.
    @(negedge clk);
    a[0] = 8'h57; b[0] = 8'h83; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    cyc = 0;
    while (!ov[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", 32'(cyc), 8);
    repeat (5) begin
      check("bp_hold_data", 32'(dout[0]), 32'h C1);
      check("bp_in_ready_low", 32'(rdy[0]), 0);
      @(negedge clk);
    end
    a[0] = 8'h02; b[0] = 8'h87; iv[0] = 1'b1; ordy[0] = 1'b1;
    #1;
    check("b2b_in_ready", 32'(rdy[0]), 1);
    check("b2b_still_valid", 32'(ov[0]), 1);
    @(negedge clk);
    iv[0] = 1'b0;
    check("b2b_no_idle_busy", 32'(bz[0]), 1);
    check("b2b_valid_cleared", 32'(ov[0]), 0);
    cyc = 0;
    while (!ov[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_latency", 32'(cyc), 8);
    check("b2b_data", 32'(dout[0]), 32'h15);
    @(negedge clk);
    check("b2b_valid_drop", 32'(ov[0]), 0);

    fork
      rand_run(0, 1000);
      rand_run(1, 1000);
      rand_run(2, 1000);
      rand_run(3, 1000);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
